// File: rtl/cpu_pkg.sv
// Shared write-back types: FSM state, result source, result beat and register-zero constant.
package cpu_pkg;

    localparam int XLEN_DEF = 32;
    localparam logic [4:0] REG_ZERO = 5'd0;

    typedef enum logic {
        RUN      = 1'b0,
        REDIRECT = 1'b1
    } wb_state_t;

    typedef enum logic {
        SRC_ALU = 1'b0,
        SRC_LSU = 1'b1
    } wb_src_t;

    typedef struct packed {
        logic [4:0]          rd;
        logic [XLEN_DEF-1:0] data;
    } wb_beat_t;

    // x0 is hard-wired, so a beat targeting it never writes the register file.
    function automatic logic writes_reg(input logic [4:0] rd);
        return (rd != REG_ZERO);
    endfunction

endpackage

// File: rtl/wb_arbiter.sv
// Two-way round-robin arbiter between ALU and LSU result channels with a last-grant register.
module wb_arbiter
    import cpu_pkg::*;
(
    input  logic    clk,
    input  logic    rst_n,
    input  logic    en,
    input  logic    req_alu,
    input  logic    req_lsu,
    output logic    gnt_alu,
    output logic    gnt_lsu,
    output wb_src_t src
);

    wb_src_t last_r;

    // Grant selection: a lone requester wins, contention goes to the channel not granted last.
    always_comb begin
        gnt_alu = 1'b0;
        gnt_lsu = 1'b0;
        if (req_alu && req_lsu) begin
            if (last_r == SRC_ALU) begin
                gnt_lsu = 1'b1;
            end else begin
                gnt_alu = 1'b1;
            end
        end else if (req_alu) begin
            gnt_alu = 1'b1;
        end else if (req_lsu) begin
            gnt_lsu = 1'b1;
        end else begin
            gnt_alu = 1'b0;
            gnt_lsu = 1'b0;
        end
        src = gnt_lsu ? SRC_LSU : SRC_ALU;
    end

    // Last-grant history, only advanced when a grant is actually consumed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_r <= SRC_ALU;
        end else if (en && (gnt_alu || gnt_lsu)) begin
            last_r <= src;
        end else begin
            last_r <= last_r;
        end
    end

endmodule

// File: rtl/wb_stage.sv
// Write-back stage: arbitrates ALU/LSU results, commits one register write per cycle,
// and turns taken jumps into a PC redirect plus flush. Optional bypass ports: WB_BYPASS_EN.
module wb_stage
    import cpu_pkg::*;
#(
    parameter int XLEN         = XLEN_DEF,
    parameter int FLUSH_CYCLES = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            alu_valid_i,
    input  logic [XLEN-1:0] alu_result_i,
    input  logic [4:0]      alu_rd_i,
    input  logic            alu_target_valid_i,
    input  logic [XLEN-1:0] alu_target_i,
    output logic            alu_ok_o,
    input  logic            lsu_valid_i,
    input  logic [XLEN-1:0] lsu_data_i,
    input  logic [4:0]      lsu_rd_i,
    output logic            lsu_ok_o,
    output logic            rf_we_o,
    output logic [4:0]      rf_waddr_o,
    output logic [XLEN-1:0] rf_wdata_o,
    output logic            clr_valid_o,
    output logic [4:0]      clr_rd_o,
    output logic            pc_target_valid_o,
    output logic [XLEN-1:0] pc_target_o,
`ifdef WB_BYPASS_EN
    output logic            byp_valid_o,
    output logic [4:0]      byp_rd_o,
    output logic [XLEN-1:0] byp_data_o,
`endif
    output logic            flush_o
);

    localparam int CNT_W = (FLUSH_CYCLES < 2) ? 1 : $clog2(FLUSH_CYCLES + 1);

    wb_state_t        state_r;
    wb_state_t        state_s;
    logic [CNT_W-1:0] cnt_r;

    logic             gnt_alu_s;
    logic             gnt_lsu_s;
    wb_src_t          src_s;
    logic             run_s;
    logic             accept_s;
    logic             branch_s;
    wb_beat_t         beat_s;

    logic             rf_we_r;
    logic [4:0]       rf_waddr_r;
    logic [XLEN-1:0]  rf_wdata_r;
    logic             clr_valid_r;
    logic [4:0]       clr_rd_r;
    logic             pc_target_valid_r;
    logic [XLEN-1:0]  pc_target_r;
    logic             flush_r;

    wb_arbiter u_arb (
        .clk     (clk),
        .rst_n   (rst_n),
        .en      (run_s),
        .req_alu (alu_valid_i),
        .req_lsu (lsu_valid_i),
        .gnt_alu (gnt_alu_s),
        .gnt_lsu (gnt_lsu_s),
        .src     (src_s)
    );

    // State register and flush counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= RUN;
            cnt_r   <= {CNT_W{1'b0}};
        end else begin
            state_r <= state_s;
            if (branch_s) begin
                cnt_r <= CNT_W'(FLUSH_CYCLES);
            end else if (state_r == REDIRECT) begin
                cnt_r <= cnt_r - CNT_W'(1);
            end else begin
                cnt_r <= cnt_r;
            end
        end
    end

    // Next-state logic: a taken jump enters REDIRECT, which exits on the counter's last cycle.
    always_comb begin
        state_s = state_r;
        case (state_r)
            RUN: begin
                if (branch_s) begin
                    state_s = REDIRECT;
                end else begin
                    state_s = RUN;
                end
            end
            REDIRECT: begin
                if (cnt_r == CNT_W'(1)) begin
                    state_s = RUN;
                end else begin
                    state_s = REDIRECT;
                end
            end
            default: state_s = RUN;
        endcase
    end

    // Handshake outputs and accept decode; REDIRECT acks everything so stale beats drain.
    always_comb begin
        alu_ok_o = 1'b0;
        lsu_ok_o = 1'b0;
        run_s    = 1'b0;
        case (state_r)
            RUN: begin
                run_s    = 1'b1;
                alu_ok_o = gnt_alu_s;
                lsu_ok_o = gnt_lsu_s;
            end
            REDIRECT: begin
                alu_ok_o = 1'b1;
                lsu_ok_o = 1'b1;
            end
            default: begin
                alu_ok_o = 1'b0;
                lsu_ok_o = 1'b0;
            end
        endcase
        accept_s = run_s && (gnt_alu_s || gnt_lsu_s);
        branch_s = run_s && gnt_alu_s && alu_target_valid_i;
        if (src_s == SRC_LSU) begin
            beat_s = '{rd: lsu_rd_i, data: lsu_data_i};
        end else begin
            beat_s = '{rd: alu_rd_i, data: alu_result_i};
        end
    end

    // Registered commit, scoreboard release, redirect and flush outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rf_we_r           <= 1'b0;
            rf_waddr_r        <= REG_ZERO;
            rf_wdata_r        <= {XLEN{1'b0}};
            clr_valid_r       <= 1'b0;
            clr_rd_r          <= REG_ZERO;
            pc_target_valid_r <= 1'b0;
            pc_target_r       <= {XLEN{1'b0}};
            flush_r           <= 1'b0;
        end else begin
            if (accept_s) begin
                rf_we_r     <= writes_reg(beat_s.rd);
                rf_waddr_r  <= beat_s.rd;
                rf_wdata_r  <= beat_s.data;
                clr_valid_r <= 1'b1;
                clr_rd_r    <= beat_s.rd;
            end else begin
                rf_we_r     <= 1'b0;
                rf_waddr_r  <= REG_ZERO;
                rf_wdata_r  <= {XLEN{1'b0}};
                clr_valid_r <= 1'b0;
                clr_rd_r    <= REG_ZERO;
            end
            if (branch_s) begin
                pc_target_valid_r <= 1'b1;
                pc_target_r       <= alu_target_i;
            end else begin
                pc_target_valid_r <= 1'b0;
                pc_target_r       <= pc_target_r;
            end
            flush_r <= (state_s == REDIRECT);
        end
    end

    assign rf_we_o           = rf_we_r;
    assign rf_waddr_o        = rf_waddr_r;
    assign rf_wdata_o        = rf_wdata_r;
    assign clr_valid_o       = clr_valid_r;
    assign clr_rd_o          = clr_rd_r;
    assign pc_target_valid_o = pc_target_valid_r;
    assign pc_target_o       = pc_target_r;
    assign flush_o           = flush_r;

`ifdef WB_BYPASS_EN
    // Early forward of the beat being accepted this cycle.
    always_comb begin
        if (accept_s) begin
            byp_valid_o = writes_reg(beat_s.rd);
            byp_rd_o    = beat_s.rd;
            byp_data_o  = beat_s.data;
        end else begin
            byp_valid_o = 1'b0;
            byp_rd_o    = REG_ZERO;
            byp_data_o  = {XLEN{1'b0}};
        end
    end
`endif

endmodule

// File: tb/tb_wb_stage.sv
// Directed bench for wb_stage with a cycle-level behavioural model and a per-cycle compare process.
module tb_wb_stage;

    localparam int XLEN = 32;
    localparam int FC   = 2;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            alu_valid_i = 1'b0;
    logic [XLEN-1:0] alu_result_i = '0;
    logic [4:0]      alu_rd_i = '0;
    logic            alu_target_valid_i = 1'b0;
    logic [XLEN-1:0] alu_target_i = '0;
    logic            alu_ok_o;
    logic            lsu_valid_i = 1'b0;
    logic [XLEN-1:0] lsu_data_i = '0;
    logic [4:0]      lsu_rd_i = '0;
    logic            lsu_ok_o;
    logic            rf_we_o;
    logic [4:0]      rf_waddr_o;
    logic [XLEN-1:0] rf_wdata_o;
    logic            clr_valid_o;
    logic [4:0]      clr_rd_o;
    logic            pc_target_valid_o;
    logic [XLEN-1:0] pc_target_o;
    logic            flush_o;
`ifdef WB_BYPASS_EN
    logic            byp_valid_o;
    logic [4:0]      byp_rd_o;
    logic [XLEN-1:0] byp_data_o;
`endif

    wb_stage #(.XLEN(XLEN), .FLUSH_CYCLES(FC)) dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .alu_valid_i        (alu_valid_i),
        .alu_result_i       (alu_result_i),
        .alu_rd_i           (alu_rd_i),
        .alu_target_valid_i (alu_target_valid_i),
        .alu_target_i       (alu_target_i),
        .alu_ok_o           (alu_ok_o),
        .lsu_valid_i        (lsu_valid_i),
        .lsu_data_i         (lsu_data_i),
        .lsu_rd_i           (lsu_rd_i),
        .lsu_ok_o           (lsu_ok_o),
        .rf_we_o            (rf_we_o),
        .rf_waddr_o         (rf_waddr_o),
        .rf_wdata_o         (rf_wdata_o),
        .clr_valid_o        (clr_valid_o),
        .clr_rd_o           (clr_rd_o),
        .pc_target_valid_o  (pc_target_valid_o),
        .pc_target_o        (pc_target_o),
`ifdef WB_BYPASS_EN
        .byp_valid_o        (byp_valid_o),
        .byp_rd_o           (byp_rd_o),
        .byp_data_o         (byp_data_o),
`endif
        .flush_o            (flush_o)
    );

    always #5 clk = ~clk;

    int n_vec  = 0;
    int n_miss = 0;
    bit chk_en = 1'b0;

    // Model: e_* are what the DUT should show now, n_* what it should register at the next edge.
    logic        e_aok = 0, e_lok = 0, e_we = 0, e_clr = 0, e_pcv = 0, e_flush = 0;
    logic [4:0]  e_waddr = 0, e_clrrd = 0;
    logic [31:0] e_wdata = 0, e_pc = 0;
    logic        n_we = 0, n_clr = 0, n_pcv = 0, n_flush = 0;
    logic [4:0]  n_waddr = 0, n_clrrd = 0;
    logic [31:0] n_wdata = 0, n_pc = 0;
    logic        e_bv = 0;
    logic [4:0]  e_brd = 0;
    logic [31:0] e_bdata = 0;
    int          m_left = 0;
    bit          m_last_lsu = 1'b0;

    function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
        end
    endfunction

    function automatic void model_reset();
        {e_aok, e_lok, e_we, e_clr, e_pcv, e_flush} = '0;
        {n_we, n_clr, n_pcv, n_flush} = '0;
        e_waddr = 0; e_clrrd = 0; e_wdata = 0; e_pc = 0;
        n_waddr = 0; n_clrrd = 0; n_wdata = 0; n_pc = 0;
        e_bv = 0; e_brd = 0; e_bdata = 0;
        m_left = 0;
        m_last_lsu = 1'b0;
    endfunction

    // Evaluate one cycle of the stage's rules against the inputs now being driven.
    function automatic void model_eval();
        bit ga, gl;
        n_we = 0; n_clr = 0; n_pcv = 0; n_waddr = 0; n_wdata = 0; n_clrrd = 0;
        n_pc = e_pc;
        e_bv = 0; e_brd = 0; e_bdata = 0;
        if (m_left > 0) begin
            e_aok = 1; e_lok = 1;
            m_left--;
        end else begin
            ga = alu_valid_i && (!lsu_valid_i || m_last_lsu);
            gl = lsu_valid_i && !ga;
            e_aok = ga; e_lok = gl;
            if (ga || gl) begin
                m_last_lsu = gl;
                n_clr   = 1;
                n_clrrd = ga ? alu_rd_i : lsu_rd_i;
                n_waddr = n_clrrd;
                n_wdata = ga ? alu_result_i : lsu_data_i;
                n_we    = (n_clrrd != 0);
                e_bv    = n_we; e_brd = n_clrrd; e_bdata = n_wdata;
                if (ga && alu_target_valid_i) begin
                    n_pcv  = 1;
                    n_pc   = alu_target_i;
                    m_left = FC;
                end
            end
        end
        n_flush = (m_left > 0);
    endfunction

    // Per-cycle comparison, half a clock away from the active edge.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("alu_ok", alu_ok_o, e_aok);
            chk("lsu_ok", lsu_ok_o, e_lok);
            chk("rf_we", rf_we_o, e_we);
            if (e_we) begin
                chk("rf_waddr", rf_waddr_o, e_waddr);
                chk("rf_wdata", rf_wdata_o, e_wdata);
            end
            chk("clr_valid", clr_valid_o, e_clr);
            if (e_clr) chk("clr_rd", clr_rd_o, e_clrrd);
            chk("pc_valid", pc_target_valid_o, e_pcv);
            if (e_pcv) chk("pc_target", pc_target_o, e_pc);
            chk("flush", flush_o, e_flush);
`ifdef WB_BYPASS_EN
            chk("byp_valid", byp_valid_o, e_bv);
            if (e_bv) begin
                chk("byp_rd", byp_rd_o, e_brd);
                chk("byp_data", byp_data_o, e_bdata);
            end
`endif
        end
    end

    task automatic cyc(input logic av, input logic [31:0] ares, input logic [4:0] ard,
                       input logic atv, input logic [31:0] atgt,
                       input logic lv, input logic [31:0] ld, input logic [4:0] lrd);
        @(posedge clk);
        e_we = n_we; e_waddr = n_waddr; e_wdata = n_wdata; e_clr = n_clr; e_clrrd = n_clrrd;
        e_pcv = n_pcv; e_pc = n_pc; e_flush = n_flush;
        #1;
        alu_valid_i = av; alu_result_i = ares; alu_rd_i = ard;
        alu_target_valid_i = atv; alu_target_i = atgt;
        lsu_valid_i = lv; lsu_data_i = ld; lsu_rd_i = lrd;
        model_eval();
        #1;
    endtask

    task automatic idle();
        cyc(1'b0, 32'h0, 5'd0, 1'b0, 32'h0, 1'b0, 32'h0, 5'd0);
    endtask

    task automatic do_reset(input int n);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        alu_valid_i = 0; alu_result_i = 0; alu_rd_i = 0; alu_target_valid_i = 0; alu_target_i = 0;
        lsu_valid_i = 0; lsu_data_i = 0; lsu_rd_i = 0;
        model_reset();
        chk_en = 1'b1;
        #1;
        chk("rst_flush", flush_o, 32'h0);
        chk("rst_pc_target", pc_target_o, 32'h0);
        chk("rst_pc_valid", pc_target_valid_o, 32'h0);
        chk("rst_rf_we", rf_we_o, 32'h0);
        repeat (n) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        do_reset(2);

        // Single ALU beat.
        cyc(1'b1, 32'h1234, 5'd5, 1'b0, 32'h0, 1'b0, 32'h0, 5'd0);
        chk("t1_alu_ok", alu_ok_o, 32'h1);
        idle();
        chk("t1_we", rf_we_o, 32'h1);
        chk("t1_waddr", rf_waddr_o, 32'd5);
        chk("t1_wdata", rf_wdata_o, 32'h1234);
        chk("t1_clr_rd", clr_rd_o, 32'd5);
        idle();
        chk("idle_we", rf_we_o, 32'h0);
        chk("idle_clr", clr_valid_o, 32'h0);

        // LSU-only beat, so the following contention starts with ALU.
        cyc(1'b0, 32'h0, 5'd0, 1'b0, 32'h0, 1'b1, 32'h70, 5'd7);
        chk("lsu_only_ok", lsu_ok_o, 32'h1);
        idle();

        // Both channels valid for four cycles: ALU, LSU, ALU, LSU.
        for (int i = 0; i < 4; i++) begin
            cyc(1'b1, 32'h300 + 32'(i), 5'd3, 1'b0, 32'h0, 1'b1, 32'h700 + 32'(i), 5'd7);
            chk("rr_alu_ok", alu_ok_o, (i % 2 == 0) ? 32'h1 : 32'h0);
            chk("rr_lsu_ok", lsu_ok_o, (i % 2 == 0) ? 32'h0 : 32'h1);
        end
        idle();
        chk("rr_last_waddr", rf_waddr_o, 32'd7);
        idle();

        // Write to x0: release but no register write.
        cyc(1'b1, 32'hFFFF, 5'd0, 1'b0, 32'h0, 1'b0, 32'h0, 5'd0);
        idle();
        chk("x0_we", rf_we_o, 32'h0);
        chk("x0_clr", clr_valid_o, 32'h1);
        chk("x0_clr_rd", clr_rd_o, 32'd0);

        // Jump with link, then an LSU beat that must be drained during the flush.
        cyc(1'b1, 32'h104, 5'd1, 1'b1, 32'h200, 1'b0, 32'h0, 5'd0);
        cyc(1'b0, 32'h0, 5'd0, 1'b0, 32'h0, 1'b1, 32'h99, 5'd9);
        chk("br_pcv", pc_target_valid_o, 32'h1);
        chk("br_pc", pc_target_o, 32'h200);
        chk("br_link_addr", rf_waddr_o, 32'd1);
        chk("br_link_data", rf_wdata_o, 32'h104);
        chk("br_flush1", flush_o, 32'h1);
        chk("br_drain_ok", lsu_ok_o, 32'h1);
        idle();
        chk("br_flush2", flush_o, 32'h1);
        chk("br_drop_we", rf_we_o, 32'h0);
        chk("br_pcv_once", pc_target_valid_o, 32'h0);
        cyc(1'b1, 32'h55, 5'd8, 1'b0, 32'h0, 1'b1, 32'h66, 5'd10);
        chk("br_flush_end", flush_o, 32'h0);
        chk("br_drop_clr", clr_valid_o, 32'h0);
        idle();
        idle();

        // Reset during a redirect, then a normal commit.
        cyc(1'b1, 32'h8, 5'd2, 1'b1, 32'h300, 1'b0, 32'h0, 5'd0);
        do_reset(1);
        cyc(1'b1, 32'h66, 5'd6, 1'b0, 32'h0, 1'b0, 32'h0, 5'd0);
        chk("post_rst_ok", alu_ok_o, 32'h1);
        idle();
        chk("post_rst_we", rf_we_o, 32'h1);
        chk("post_rst_waddr", rf_waddr_o, 32'd6);
        chk("post_rst_wdata", rf_wdata_o, 32'h66);
        chk("post_rst_flush", flush_o, 32'h0);

`ifdef WB_BYPASS_EN
        cyc(1'b1, 32'hAA, 5'd4, 1'b0, 32'h0, 1'b0, 32'h0, 5'd0);
        chk("byp_v", byp_valid_o, 32'h1);
        chk("byp_rd_lit", byp_rd_o, 32'd4);
        chk("byp_data_lit", byp_data_o, 32'hAA);
        idle();
`endif

        // Sustained back-to-back mixed traffic.
        for (int i = 0; i < 12; i++) begin
            cyc(i % 3 != 2, 32'h1000 + 32'(i), 5'(i + 11), 1'b0, 32'h0,
                i % 2 == 0, 32'h2000 + 32'(i), 5'(i + 1));
        end
        idle();
        idle();

        @(negedge clk);
        chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/wb_stage.md
# wb_stage

Write-back stage at the receiving end of the ALU and LSU result pipelines. It accepts result beats through valid/ok handshakes and arbitrates between the two channels. It commits one register write per cycle, releases the destination in the scoreboard, and turns a taken ALU jump/branch into a PC redirect plus a pipeline flush.

## Interface
- XLEN, 32, datapath width
- FLUSH_CYCLES, 2, cycles flush_o stays high after a redirect (≥1)
- clk  in  1  clock
- rst_n  in  1  reset; one clock, reset asynchronous and active-low
- alu_valid_i  in  1  ALU result beat valid
- alu_result_i  in  XLEN  ALU result data
- alu_rd_i  in  5  ALU destination register
- alu_target_valid_i  in  1  beat carries a taken jump/branch
- alu_target_i  in  XLEN  jump/branch target
- alu_ok_o  out  1  ALU beat accepted this cycle
- lsu_valid_i  in  1  load data valid
- lsu_data_i  in  XLEN  load data
- lsu_rd_i  in  5  load destination register
- lsu_ok_o  out  1  LSU beat accepted this cycle
- rf_we_o  out  1  register file write enable
- rf_waddr_o  out  5  write address
- rf_wdata_o  out  XLEN  write data
- clr_valid_o  out  1  scoreboard release strobe
- clr_rd_o  out  5  register to release
- pc_target_valid_o  out  1  one-cycle redirect strobe
- pc_target_o  out  XLEN  redirect address
- flush_o  out  1  pipeline flush to fetch/decode/ALU/LSU

## Operation
- The FSM has two states, RUN and REDIRECT. Reset enters RUN.
- RUN, arbitration:
  - If only one channel is valid, grant that channel.
  - If both are valid, grant the channel not granted last; the last-grant bit resets to ALU.
  - The granted channel's ok is asserted combinationally in the same cycle. The other ok is 0.
- Accepted beat:
  - Register rf_we/rf_waddr/rf_wdata and clr_valid/clr_rd.
  - If rd==0, force rf_we_o=0 but still assert clr_valid_o with clr_rd_o=0.
- Accepted ALU beat with alu_target_valid_i=1:
  - Write rd as normal (link value).
  - Register pc_target_o and pulse pc_target_valid_o.
  - Load the flush counter with FLUSH_CYCLES and go to REDIRECT.
- REDIRECT:
  - flush_o=1.
  - alu_ok_o=lsu_ok_o=1: any valid beat is drained and dropped, with no rf write and no clr.
  - The counter decrements each cycle; on the cycle it reaches 1, return to RUN.
- Nothing valid in RUN: all strobes are 0 next cycle.
- Asynchronous reset mid-REDIRECT aborts the flush. All outputs go to 0 immediately.

## Timing
- Reset values: every output is 0, including the ok outputs and pc_target_o.
- Latency: a beat accepted at cycle N produces rf_we_o/clr_valid_o at N+1, for exactly one cycle.
- Redirect:
  - Branch accepted at N: pc_target_valid_o=1 at N+1 only.
  - flush_o=1 for cycles N+1..N+FLUSH_CYCLES.
  - Arbitration resumes at N+FLUSH_CYCLES+1.
  - Beats presented at cycle N+1 are already dropped.
- Back-to-back: one commit per cycle, sustained. Two valid channels alternate every cycle.
- There are no combinational paths from the rf/clr/pc outputs to the inputs. The ok outputs depend combinationally only on the valids and state.

## Configuration
- WB_BYPASS_EN defined:
  - Adds the outputs byp_valid_o (1), byp_rd_o (5) and byp_data_o (XLEN).
  - These are driven combinationally from the granted beat in the accept cycle, so decode can forward one cycle earlier.
  - byp_valid_o is 0 when rd==0 or in REDIRECT.
- Undefined: the ports are absent and behaviour is otherwise identical.

## Structure
- Shared package (cpu_pkg) holds:
  - wb_state_t enum {RUN, REDIRECT}
  - wb_src_t enum {SRC_ALU, SRC_LSU}
  - the packed wb_beat_t {rd, data}
  - constant REG_ZERO=5'd0
- One natural sub-module: wb_arbiter, a 2-way round-robin arbiter with a last-grant register. The rest stays in wb_stage.

## Test plan
- ALU beat rd=5, result=0x1234 at N → rf_we=1, waddr=5, wdata=0x1234, clr_rd=5 at N+1; alu_ok=1 at N.
- ALU and LSU valid for 4 cycles (rd 3 and rd 7) → grants ALU, LSU, ALU, LSU; four writes in consecutive cycles.
- ALU beat rd=0, result=0xFFFF → rf_we=0, clr_valid=1, clr_rd=0.
- ALU jump rd=1, result=0x104, target=0x200 at N → write x1=0x104 and pc_target_valid=1/pc_target=0x200 at N+1; flush_o high at N+1 and N+2; an LSU beat rd=9 at N+1 is acked but never written.
- rst_n pulled low at N+1 of a redirect → flush_o and all strobes drop immediately; after release, a new ALU beat commits normally.
- With WB_BYPASS_EN: ALU beat rd=4, data=0xAA at N → byp_valid=1, byp_rd=4, byp_data=0xAA in cycle N.
